// File: rtl/rx_module.sv
// UART receiver: 2-FF synchroniser, 16x oversampling, 5-8 data bits,
// optional even parity, 1 or 2 stop bits, one-cycle valid strobe.
module rx_module #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int DATA_COUNTER_W  = 3,
    parameter int STOP_CONF_W     = 2,
    parameter int DATA_CONF_W     = 2,
    parameter int SAMPLE_COUNT_W  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  baud_en_i,
    input  logic                                  rx_en_i,
    input  logic [DATA_CONF_W+STOP_CONF_W:0]      rx_conf_i,
    input  logic                                  uart_rx_i,
    output logic [MAX_UART_DATA_W-1:0]            rx_data_o,
    output logic                                  rx_valid_o,
    output logic                                  rx_parity_err_o,
    output logic                                  rx_frame_err_o,
    output logic                                  rx_busy_o
);

    localparam int CONF_W = DATA_CONF_W + STOP_CONF_W + 1;
    localparam int MIN_BITS = 5;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]                 r_state;
    logic                       r_rx_meta;
    logic                       r_rx_s;
    logic                       r_rx_prev;
    logic [SAMPLE_COUNT_W-1:0]  r_cnt;
    logic [CONF_W-1:0]          r_conf;
    logic [MAX_UART_DATA_W-1:0] r_shift;
    logic [DATA_COUNTER_W-1:0]  r_idx;
    logic                       r_par_err;
    logic                       r_frm_err;
    logic                       r_stop2;
    logic [MAX_UART_DATA_W-1:0] r_data;
    logic                       r_valid;
    logic                       r_par_out;
    logic                       r_frm_out;

    logic                       w_mid;
    logic                       w_full;
    logic                       w_par_en;
    logic                       w_two_stop;
    logic [DATA_COUNTER_W-1:0]  w_last_idx;

    // Mid-start is the 7->8 tick; later samples land 16 ticks apart.
    assign w_mid = baud_en_i &&
        (r_cnt == SAMPLE_COUNT_W'(2 ** (SAMPLE_COUNT_W - 1) - 1));
    assign w_full = baud_en_i && (r_cnt == '1);
    assign w_par_en = r_conf[0];
    assign w_two_stop = |r_conf[STOP_CONF_W:1];
    assign w_last_idx = DATA_COUNTER_W'(MIN_BITS - 1) +
        DATA_COUNTER_W'(r_conf[CONF_W-1:STOP_CONF_W+1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_conf    <= '0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_stop2   <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_par_out <= 1'b0;
            r_frm_out <= 1'b0;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
            r_valid   <= 1'b0;
            if (baud_en_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state != IDLE && !rx_en_i) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // Needs a true 1->0 edge, so a held break never re-arms.
                        if (rx_en_i && r_rx_prev && !r_rx_s) begin
                            r_state   <= START;
                            r_cnt     <= '0;
                            r_conf    <= rx_conf_i;
                            r_shift   <= '0;
                            r_idx     <= '0;
                            r_par_err <= 1'b0;
                            r_frm_err <= 1'b0;
                            r_stop2   <= 1'b0;
                        end
                    end
                    START: begin
                        if (w_mid) begin
                            r_cnt   <= '0;
                            r_state <= r_rx_s ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        if (w_full) begin
                            r_shift[r_idx] <= r_rx_s;
                            r_idx <= r_idx + 1'b1;
                            if (r_idx == w_last_idx) begin
                                r_cnt   <= '0;
                                r_state <= w_par_en ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (w_full) begin
                            r_par_err <= (^r_shift) ^ r_rx_s;
                            r_cnt     <= '0;
                            r_state   <= STOP;
                        end
                    end
                    STOP: begin
                        if (w_full) begin
                            if (w_two_stop && !r_stop2) begin
                                r_stop2   <= 1'b1;
                                r_frm_err <= !r_rx_s;
                            end else begin
                                r_state   <= IDLE;
                                r_cnt     <= '0;
                                r_valid   <= 1'b1;
                                r_data    <= r_shift;
                                r_par_out <= r_par_err;
                                r_frm_out <= r_frm_err | !r_rx_s;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_data_o       = r_data;
    assign rx_valid_o      = r_valid;
    assign rx_parity_err_o = r_par_out;
    assign rx_frame_err_o  = r_frm_out;
    assign rx_busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_rx_module.sv
// Scoreboard bench for rx_module: directed serial frames at 16 clk/bit,
// expected words queued at stimulus time and checked by a strobe monitor.
module tb_rx_module;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b1;
    logic       rx_en = 1'b1;
    logic [4:0] conf = 5'b11000;
    logic       line = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_busy;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   strobes = 0;
    int   exp_strobes = 0;

    rx_module dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .baud_en_i       (baud_en),
        .rx_en_i         (rx_en),
        .rx_conf_i       (conf),
        .uart_rx_i       (line),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .rx_parity_err_o (rx_perr),
        .rx_frame_err_o  (rx_ferr),
        .rx_busy_o       (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            exp_t e;
            strobes++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe: got unexpected word %0h expected none",
                         rx_data);
            end else begin
                e = q.pop_front();
                chk("data", {24'd0, rx_data}, {24'd0, e.data});
                chk("parity_err", {31'd0, rx_perr}, {31'd0, e.perr});
                chk("frame_err", {31'd0, rx_ferr}, {31'd0, e.ferr});
            end
        end
    end

    task automatic expect_word(input logic [7:0] d, input logic pe,
                               input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        q.push_back(e);
        exp_strobes++;
    endtask

    task automatic bit_out(input logic v);
        line = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int nbits,
                        input logic par, input logic pbit,
                        input logic two, input logic s1, input logic s2);
        bit_out(1'b0);
        for (int i = 0; i < nbits; i++) bit_out(d[i]);
        if (par) bit_out(pbit);
        bit_out(s1);
        if (two) bit_out(s2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_data", {24'd0, rx_data}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        chk("reset_errs", {30'd0, rx_perr, rx_ferr}, 32'd0);
        rst = 1'b0;
        idle(20);

        // 0xAA, 8N1; mid-frame conf change must be ignored
        expect_word(8'hAA, 1'b0, 1'b0);
        fork
            send(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (40) @(negedge clk);
                conf = 5'b00011;
            end
        join
        idle(4);
        chk("busy_after_aa", {31'd0, rx_busy}, 32'd0);
        chk("strobes_aa", strobes, exp_strobes);
        idle(20);

        // 5 bits, even parity
        conf = 5'b00011;
        expect_word(8'h13, 1'b0, 1'b0);
        send(8'h13, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(20);
        expect_word(8'h13, 1'b1, 1'b0);
        send(8'h13, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        // 2 stop bits, second one low
        conf = 5'b11010;
        expect_word(8'h5C, 1'b0, 1'b1);
        send(8'h5C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(30);

        // break: line low for 12 bit times
        expect_word(8'h00, 1'b0, 1'b1);
        line = 1'b0;
        repeat (185) @(negedge clk);
        chk("break_no_rearm", {31'd0, rx_busy}, 32'd0);
        repeat (7) @(negedge clk);
        idle(40);
        chk("strobes_break", strobes, exp_strobes);

        // glitch, then a real frame
        conf = 5'b11000;
        line = 1'b0;
        repeat (4) @(negedge clk);
        idle(14);
        chk("glitch_busy", {31'd0, rx_busy}, 32'd0);
        idle(20);
        expect_word(8'h3C, 1'b0, 1'b0);
        send(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        // enable dropped during bit 3
        fork
            send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (72) @(negedge clk);
                rx_en = 1'b0;
                repeat (3) @(negedge clk);
                chk("abort_busy", {31'd0, rx_busy}, 32'd0);
                chk("abort_data_held", {24'd0, rx_data}, 32'h3C);
            end
        join
        idle(20);
        rx_en = 1'b1;
        idle(10);
        expect_word(8'h81, 1'b0, 1'b0);
        send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        // reset mid-frame
        fork
            send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (80) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                chk("rst_data", {24'd0, rx_data}, 32'd0);
                chk("rst_busy", {31'd0, rx_busy}, 32'd0);
            end
        join
        rst = 1'b0;
        idle(20);
        expect_word(8'h81, 1'b0, 1'b0);
        send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        // back-to-back frames as a transmitter would emit them
        expect_word(8'h00, 1'b0, 1'b0);
        expect_word(8'hFF, 1'b0, 1'b0);
        expect_word(8'hA5, 1'b0, 1'b0);
        send(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(40);

        chk("strobes_total", strobes, exp_strobes);
        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
